clint: RTL and testbench



---
 rtl/clint_pkg.sv | 39 +++
 rtl/clint.sv | 140 ++++++++++++++
 tb/tb_clint.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/clint_pkg.sv
// Shared CSR addresses, instruction encodings and trap causes for the core-local
// interrupt sequencer, plus the mstatus trap-entry/return transforms.
package clint_pkg;

  localparam logic [31:0] CSR_MSTATUS = 32'h0000_0300;
  localparam logic [31:0] CSR_MTVEC   = 32'h0000_0305;
  localparam logic [31:0] CSR_MEPC    = 32'h0000_0341;
  localparam logic [31:0] CSR_MCAUSE  = 32'h0000_0342;

  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INST_MRET   = 32'h3020_0073;

  localparam logic [31:0] CAUSE_ECALL  = 32'd11;
  localparam logic [31:0] CAUSE_EBREAK = 32'd3;
  localparam logic [31:0] CAUSE_TIMER  = 32'h8000_0007;

  localparam int unsigned MSTATUS_MIE  = 3;
  localparam int unsigned MSTATUS_MPIE = 7;

  // Trap entry: stash MIE into MPIE, then disable interrupts.
  function automatic logic [31:0] mstatus_trap(input logic [31:0] old);
    logic [31:0] v;
    v = old;
    v[MSTATUS_MPIE] = old[MSTATUS_MIE];
    v[MSTATUS_MIE]  = 1'b0;
    return v;
  endfunction

  // Trap return: restore MIE from MPIE and set MPIE.
  function automatic logic [31:0] mstatus_mret(input logic [31:0] old);
    logic [31:0] v;
    v = old;
    v[MSTATUS_MIE]  = old[MSTATUS_MPIE];
    v[MSTATUS_MPIE] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/clint.sv
// Core-local interrupt/exception sequencer: detects ECALL/EBREAK/MRET/timer interrupt,
// stalls the pipeline, performs the mepc/mstatus/mcause CSR updates and redirects fetch.
module clint
  import clint_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        int_flag_i,
  input  logic [31:0] inst_i,
  input  logic [31:0] inst_addr_i,
  input  logic        jump_flag_i,
  input  logic [31:0] jump_addr_i,
  input  logic        hold_flag_i,
  output logic [31:0] csr_raddr_o,
  input  logic [31:0] csr_data_i,
  output logic        csr_we_o,
  output logic [31:0] csr_waddr_o,
  output logic [31:0] csr_wdata_o,
  output logic        hold_flag_o,
  output logic        int_assert_o,
  output logic [31:0] int_addr_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_W_MEPC,
    S_W_MSTATUS,
    S_W_MCAUSE,
    S_ASSERT,
    S_R_MSTATUS,
    S_R_ASSERT
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] epc;
  logic [31:0] cause;

  logic        is_ecall;
  logic        is_ebreak;
  logic        is_mret;
  logic        is_int;
  logic        trap_event;
  logic [31:0] trap_cause;
  logic [31:0] trap_epc;

  // In IDLE the read port points at mstatus, so csr_data_i carries MIE here.
  assign is_ecall   = (inst_i == INST_ECALL);
  assign is_ebreak  = (inst_i == INST_EBREAK);
  assign is_mret    = (inst_i == INST_MRET);
  assign is_int     = int_flag_i & csr_data_i[MSTATUS_MIE] & ~hold_flag_i;
  assign trap_event = is_ecall | is_ebreak | (~is_mret & is_int);

  always_comb begin
    trap_cause = CAUSE_TIMER;
    trap_epc   = jump_flag_i ? jump_addr_i : inst_addr_i + 32'd4;
    if (is_ecall) begin
      trap_cause = CAUSE_ECALL;
      trap_epc   = inst_addr_i;
    end else if (is_ebreak) begin
      trap_cause = CAUSE_EBREAK;
      trap_epc   = inst_addr_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      epc   <= '0;
      cause <= '0;
    end else begin
      state <= state_next;
      if (state == S_IDLE && trap_event) begin
        epc   <= trap_epc;
        cause <= trap_cause;
      end
    end
  end

  always_comb begin
    state_next   = state;
    csr_raddr_o  = CSR_MSTATUS;
    csr_we_o     = 1'b0;
    csr_waddr_o  = '0;
    csr_wdata_o  = '0;
    hold_flag_o  = 1'b1;
    int_assert_o = 1'b0;
    int_addr_o   = '0;
    case (state)
      S_IDLE: begin
        hold_flag_o = 1'b0;
        if (trap_event) begin
          state_next = S_W_MEPC;
        end else if (is_mret) begin
          state_next = S_R_MSTATUS;
        end
      end
      S_W_MEPC: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = CSR_MEPC;
        csr_wdata_o = epc;
        state_next  = S_W_MSTATUS;
      end
      S_W_MSTATUS: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = CSR_MSTATUS;
        csr_wdata_o = mstatus_trap(csr_data_i);
        state_next  = S_W_MCAUSE;
      end
      S_W_MCAUSE: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = CSR_MCAUSE;
        csr_wdata_o = cause;
        state_next  = S_ASSERT;
      end
      S_ASSERT: begin
        csr_raddr_o  = CSR_MTVEC;
        int_assert_o = 1'b1;
        int_addr_o   = csr_data_i;
        state_next   = S_IDLE;
      end
      S_R_MSTATUS: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = CSR_MSTATUS;
        csr_wdata_o = mstatus_mret(csr_data_i);
        state_next  = S_R_ASSERT;
      end
      S_R_ASSERT: begin
        csr_raddr_o  = CSR_MEPC;
        int_assert_o = 1'b1;
        int_addr_o   = csr_data_i;
        state_next   = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_clint.sv
// Directed testbench for clint: a small CSR-file model answers the read port and
// absorbs writes; each task checks cycle-by-cycle port behaviour against hand values.
module tb_clint;

  logic        clk;
  logic        rst;
  logic        int_flag_i;
  logic [31:0] inst_i;
  logic [31:0] inst_addr_i;
  logic        jump_flag_i;
  logic [31:0] jump_addr_i;
  logic        hold_flag_i;
  logic [31:0] csr_raddr_o;
  logic [31:0] csr_data_i;
  logic        csr_we_o;
  logic [31:0] csr_waddr_o;
  logic [31:0] csr_wdata_o;
  logic        hold_flag_o;
  logic        int_assert_o;
  logic [31:0] int_addr_o;

  logic        core_we;
  logic [31:0] core_waddr;
  logic [31:0] core_wdata;
  logic [31:0] m_mstatus;
  logic [31:0] m_mtvec;
  logic [31:0] m_mepc;
  logic [31:0] m_mcause;

  int checks;
  int failures;

  clint dut (
    .clk         (clk),
    .rst         (rst),
    .int_flag_i  (int_flag_i),
    .inst_i      (inst_i),
    .inst_addr_i (inst_addr_i),
    .jump_flag_i (jump_flag_i),
    .jump_addr_i (jump_addr_i),
    .hold_flag_i (hold_flag_i),
    .csr_raddr_o (csr_raddr_o),
    .csr_data_i  (csr_data_i),
    .csr_we_o    (csr_we_o),
    .csr_waddr_o (csr_waddr_o),
    .csr_wdata_o (csr_wdata_o),
    .hold_flag_o (hold_flag_o),
    .int_assert_o(int_assert_o),
    .int_addr_o  (int_addr_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // CSR file model: core port has priority over the clint port.
  always @(posedge clk) begin
    if (core_we) begin
      case (core_waddr[11:0])
        12'h300: m_mstatus <= core_wdata;
        12'h305: m_mtvec   <= core_wdata;
        12'h341: m_mepc    <= core_wdata;
        12'h342: m_mcause  <= core_wdata;
        default: ;
      endcase
    end else if (csr_we_o) begin
      case (csr_waddr_o[11:0])
        12'h300: m_mstatus <= csr_wdata_o;
        12'h305: m_mtvec   <= csr_wdata_o;
        12'h341: m_mepc    <= csr_wdata_o;
        12'h342: m_mcause  <= csr_wdata_o;
        default: ;
      endcase
    end
  end

  always_comb begin
    csr_data_i = 32'h0;
    case (csr_raddr_o[11:0])
      12'h300: csr_data_i = m_mstatus;
      12'h305: csr_data_i = m_mtvec;
      12'h341: csr_data_i = m_mepc;
      12'h342: csr_data_i = m_mcause;
      default: csr_data_i = 32'h0;
    endcase
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_csr(input logic [31:0] a, input logic [31:0] d);
    core_we = 1'b1; core_waddr = a; core_wdata = d;
    step();
    core_we = 1'b0; core_waddr = 32'h0; core_wdata = 32'h0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++; if (hold_flag_o !== 1'b0) begin failures++; $display("[TB] FAIL rst_hold got=%0h exp=0", hold_flag_o); end
    checks++; if (int_assert_o !== 1'b0) begin failures++; $display("[TB] FAIL rst_assert got=%0h exp=0", int_assert_o); end
    checks++; if (csr_we_o !== 1'b0) begin failures++; $display("[TB] FAIL rst_we got=%0h exp=0", csr_we_o); end
    checks++; if (csr_waddr_o !== 32'h0) begin failures++; $display("[TB] FAIL rst_waddr got=%h exp=0", csr_waddr_o); end
    checks++; if (csr_wdata_o !== 32'h0) begin failures++; $display("[TB] FAIL rst_wdata got=%h exp=0", csr_wdata_o); end
    checks++; if (int_addr_o !== 32'h0) begin failures++; $display("[TB] FAIL rst_int_addr got=%h exp=0", int_addr_o); end
    checks++; if (csr_raddr_o !== 32'h300) begin failures++; $display("[TB] FAIL rst_raddr got=%h exp=300", csr_raddr_o); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_ecall();
    set_csr(32'h305, 32'h200);
    set_csr(32'h300, 32'h8);
    inst_addr_i = 32'h100; inst_i = 32'h0000_0073;
    step();
    inst_i = 32'h13;
    checks++; if (csr_we_o !== 1'b1 || csr_waddr_o !== 32'h341 || csr_wdata_o !== 32'h100) begin failures++; $display("[TB] FAIL ecall_w_mepc got=%0h/%h/%h exp=1/341/100", csr_we_o, csr_waddr_o, csr_wdata_o); end
    checks++; if (hold_flag_o !== 1'b1 || int_assert_o !== 1'b0) begin failures++; $display("[TB] FAIL ecall_hold_n1 got=%0h/%0h exp=1/0", hold_flag_o, int_assert_o); end
    step();
    checks++; if (csr_we_o !== 1'b1 || csr_waddr_o !== 32'h300 || csr_wdata_o !== 32'h80) begin failures++; $display("[TB] FAIL ecall_w_mstatus got=%0h/%h/%h exp=1/300/80", csr_we_o, csr_waddr_o, csr_wdata_o); end
    checks++; if (hold_flag_o !== 1'b1) begin failures++; $display("[TB] FAIL ecall_hold_n2 got=%0h exp=1", hold_flag_o); end
    step();
    checks++; if (csr_we_o !== 1'b1 || csr_waddr_o !== 32'h342 || csr_wdata_o !== 32'd11) begin failures++; $display("[TB] FAIL ecall_w_mcause got=%0h/%h/%h exp=1/342/b", csr_we_o, csr_waddr_o, csr_wdata_o); end
    checks++; if (hold_flag_o !== 1'b1) begin failures++; $display("[TB] FAIL ecall_hold_n3 got=%0h exp=1", hold_flag_o); end
    step();
    checks++; if (int_assert_o !== 1'b1 || int_addr_o !== 32'h200) begin failures++; $display("[TB] FAIL ecall_assert got=%0h/%h exp=1/200", int_assert_o, int_addr_o); end
    checks++; if (hold_flag_o !== 1'b1 || csr_we_o !== 1'b0 || csr_waddr_o !== 32'h0 || csr_wdata_o !== 32'h0) begin failures++; $display("[TB] FAIL ecall_n4_port got=%0h/%0h/%h/%h exp=1/0/0/0", hold_flag_o, csr_we_o, csr_waddr_o, csr_wdata_o); end
    step();
    checks++; if (hold_flag_o !== 1'b0 || int_assert_o !== 1'b0 || int_addr_o !== 32'h0) begin failures++; $display("[TB] FAIL ecall_idle got=%0h/%0h/%h exp=0/0/0", hold_flag_o, int_assert_o, int_addr_o); end
    checks++; if (m_mepc !== 32'h100 || m_mstatus !== 32'h80 || m_mcause !== 32'd11) begin failures++; $display("[TB] FAIL ecall_csrs got=%h/%h/%h exp=100/80/b", m_mepc, m_mstatus, m_mcause); end
  endtask

  task automatic test_ebreak();
    set_csr(32'h300, 32'h8);
    inst_addr_i = 32'h208; inst_i = 32'h0010_0073;
    step();
    inst_i = 32'h13;
    checks++; if (csr_waddr_o !== 32'h341 || csr_wdata_o !== 32'h208) begin failures++; $display("[TB] FAIL ebreak_mepc got=%h/%h exp=341/208", csr_waddr_o, csr_wdata_o); end
    step();
    step();
    checks++; if (csr_waddr_o !== 32'h342 || csr_wdata_o !== 32'd3) begin failures++; $display("[TB] FAIL ebreak_mcause got=%h/%h exp=342/3", csr_waddr_o, csr_wdata_o); end
    step();
    step();
  endtask

  task automatic test_mret();
    set_csr(32'h341, 32'h104);
    set_csr(32'h300, 32'h80);
    inst_i = 32'h3020_0073;
    step();
    inst_i = 32'h13;
    checks++; if (csr_we_o !== 1'b1 || csr_waddr_o !== 32'h300 || csr_wdata_o !== 32'h88) begin failures++; $display("[TB] FAIL mret_w_mstatus got=%0h/%h/%h exp=1/300/88", csr_we_o, csr_waddr_o, csr_wdata_o); end
    checks++; if (hold_flag_o !== 1'b1 || int_assert_o !== 1'b0) begin failures++; $display("[TB] FAIL mret_hold_n1 got=%0h/%0h exp=1/0", hold_flag_o, int_assert_o); end
    step();
    checks++; if (int_assert_o !== 1'b1 || int_addr_o !== 32'h104) begin failures++; $display("[TB] FAIL mret_assert got=%0h/%h exp=1/104", int_assert_o, int_addr_o); end
    checks++; if (csr_we_o !== 1'b0 || hold_flag_o !== 1'b1) begin failures++; $display("[TB] FAIL mret_n2_port got=%0h/%0h exp=0/1", csr_we_o, hold_flag_o); end
    step();
    checks++; if (hold_flag_o !== 1'b0 || int_assert_o !== 1'b0) begin failures++; $display("[TB] FAIL mret_idle got=%0h/%0h exp=0/0", hold_flag_o, int_assert_o); end
  endtask

  task automatic test_int_gating();
    set_csr(32'h300, 32'h0);
    int_flag_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (hold_flag_o !== 1'b0) begin failures++; $display("[TB] FAIL int_mie0_hold[%0d] got=%0h exp=0", i, hold_flag_o); end
    end
    hold_flag_i = 1'b1;
    set_csr(32'h300, 32'h8);
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (hold_flag_o !== 1'b0) begin failures++; $display("[TB] FAIL int_held_hold[%0d] got=%0h exp=0", i, hold_flag_o); end
    end
    hold_flag_i = 1'b0; inst_addr_i = 32'h40;
    step();
    checks++; if (csr_waddr_o !== 32'h341 || csr_wdata_o !== 32'h44) begin failures++; $display("[TB] FAIL int_mepc got=%h/%h exp=341/44", csr_waddr_o, csr_wdata_o); end
    step();
    checks++; if (csr_waddr_o !== 32'h300 || csr_wdata_o !== 32'h80) begin failures++; $display("[TB] FAIL int_mstatus got=%h/%h exp=300/80", csr_waddr_o, csr_wdata_o); end
    step();
    checks++; if (csr_waddr_o !== 32'h342 || csr_wdata_o !== 32'h8000_0007) begin failures++; $display("[TB] FAIL int_mcause got=%h/%h exp=342/80000007", csr_waddr_o, csr_wdata_o); end
    step();
    checks++; if (int_assert_o !== 1'b1 || int_addr_o !== 32'h200) begin failures++; $display("[TB] FAIL int_assert got=%0h/%h exp=1/200", int_assert_o, int_addr_o); end
    for (int i = 0; i < 2; i++) begin
      step();
      checks++; if (hold_flag_o !== 1'b0) begin failures++; $display("[TB] FAIL int_masked_after[%0d] got=%0h exp=0", i, hold_flag_o); end
    end
    int_flag_i = 1'b0;
  endtask

  task automatic test_int_jump();
    set_csr(32'h300, 32'h8);
    inst_addr_i = 32'h40; jump_flag_i = 1'b1; jump_addr_i = 32'h300; int_flag_i = 1'b1;
    step();
    int_flag_i = 1'b0; jump_flag_i = 1'b0; jump_addr_i = 32'h0;
    checks++; if (csr_we_o !== 1'b1 || csr_waddr_o !== 32'h341 || csr_wdata_o !== 32'h300) begin failures++; $display("[TB] FAIL jump_mepc got=%0h/%h/%h exp=1/341/300", csr_we_o, csr_waddr_o, csr_wdata_o); end
    step();
    step();
    step();
    checks++; if (int_assert_o !== 1'b1 || int_addr_o !== 32'h200) begin failures++; $display("[TB] FAIL jump_assert got=%0h/%h exp=1/200", int_assert_o, int_addr_o); end
    step();
  endtask

  task automatic test_priority();
    set_csr(32'h300, 32'h8);
    inst_addr_i = 32'h80; inst_i = 32'h0000_0073; int_flag_i = 1'b1;
    step();
    inst_i = 32'h13;
    checks++; if (csr_waddr_o !== 32'h341 || csr_wdata_o !== 32'h80) begin failures++; $display("[TB] FAIL prio_mepc got=%h/%h exp=341/80", csr_waddr_o, csr_wdata_o); end
    step();
    step();
    checks++; if (csr_waddr_o !== 32'h342 || csr_wdata_o !== 32'd11) begin failures++; $display("[TB] FAIL prio_cause got=%h/%h exp=342/b", csr_waddr_o, csr_wdata_o); end
    step();
    for (int i = 0; i < 2; i++) begin
      step();
      checks++; if (hold_flag_o !== 1'b0) begin failures++; $display("[TB] FAIL prio_no_retrap[%0d] got=%0h exp=0", i, hold_flag_o); end
    end
    int_flag_i = 1'b0;
  endtask

  task automatic test_reset_mid();
    set_csr(32'h300, 32'h8);
    inst_addr_i = 32'h100; inst_i = 32'h0000_0073;
    step();
    inst_i = 32'h13;
    step();
    checks++; if (csr_waddr_o !== 32'h300) begin failures++; $display("[TB] FAIL rmid_in_w_mstatus got=%h exp=300", csr_waddr_o); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (hold_flag_o !== 1'b0 || csr_we_o !== 1'b0 || int_assert_o !== 1'b0) begin failures++; $display("[TB] FAIL rmid_idle got=%0h/%0h/%0h exp=0/0/0", hold_flag_o, csr_we_o, int_assert_o); end
    checks++; if (csr_waddr_o !== 32'h0 || csr_wdata_o !== 32'h0 || int_addr_o !== 32'h0 || csr_raddr_o !== 32'h300) begin failures++; $display("[TB] FAIL rmid_buses got=%h/%h/%h/%h exp=0/0/0/300", csr_waddr_o, csr_wdata_o, int_addr_o, csr_raddr_o); end
    set_csr(32'h300, 32'h8);
    inst_addr_i = 32'h120; inst_i = 32'h0000_0073;
    step();
    inst_i = 32'h13;
    checks++; if (csr_waddr_o !== 32'h341 || csr_wdata_o !== 32'h120) begin failures++; $display("[TB] FAIL rmid_fresh_mepc got=%h/%h exp=341/120", csr_waddr_o, csr_wdata_o); end
    step();
    checks++; if (csr_waddr_o !== 32'h300 || csr_wdata_o !== 32'h80) begin failures++; $display("[TB] FAIL rmid_fresh_mstatus got=%h/%h exp=300/80", csr_waddr_o, csr_wdata_o); end
    step();
    checks++; if (csr_waddr_o !== 32'h342 || csr_wdata_o !== 32'd11) begin failures++; $display("[TB] FAIL rmid_fresh_mcause got=%h/%h exp=342/b", csr_waddr_o, csr_wdata_o); end
    step();
    checks++; if (int_assert_o !== 1'b1 || int_addr_o !== 32'h200) begin failures++; $display("[TB] FAIL rmid_fresh_assert got=%0h/%h exp=1/200", int_assert_o, int_addr_o); end
    step();
    checks++; if (hold_flag_o !== 1'b0) begin failures++; $display("[TB] FAIL rmid_fresh_idle got=%0h exp=0", hold_flag_o); end
  endtask

  task automatic test_back_to_back();
    set_csr(32'h300, 32'h8);
    inst_addr_i = 32'h100; inst_i = 32'h0000_0073;
    step();
    inst_i = 32'h13;
    step();
    step();
    step();
    inst_i = 32'h3020_0073;
    checks++; if (int_assert_o !== 1'b1) begin failures++; $display("[TB] FAIL b2b_trap_assert got=%0h exp=1", int_assert_o); end
    step();
    checks++; if (hold_flag_o !== 1'b0) begin failures++; $display("[TB] FAIL b2b_idle got=%0h exp=0", hold_flag_o); end
    step();
    inst_i = 32'h13;
    checks++; if (csr_we_o !== 1'b1 || csr_waddr_o !== 32'h300 || csr_wdata_o !== 32'h88) begin failures++; $display("[TB] FAIL b2b_mret_mstatus got=%0h/%h/%h exp=1/300/88", csr_we_o, csr_waddr_o, csr_wdata_o); end
    step();
    checks++; if (int_assert_o !== 1'b1 || int_addr_o !== 32'h100) begin failures++; $display("[TB] FAIL b2b_mret_assert got=%0h/%h exp=1/100", int_assert_o, int_addr_o); end
    step();
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b0; int_flag_i = 1'b0; inst_i = 32'h13; inst_addr_i = 32'h0;
    jump_flag_i = 1'b0; jump_addr_i = 32'h0; hold_flag_i = 1'b0;
    core_we = 1'b0; core_waddr = 32'h0; core_wdata = 32'h0;
    test_reset();
    test_ecall();
    test_ebreak();
    test_mret();
    test_int_gating();
    test_int_jump();
    test_priority();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
